// File: rtl/axi_rd_pkg.sv
// rtl/axi_rd_pkg.sv - shared state type and response codes for the AXI read SRAM slave
package axi_rd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [1:0]  RESP_OKAY    = 2'b00;
    localparam logic [1:0]  RESP_SLVERR  = 2'b10;
    localparam logic [31:0] DEFAULT_BASE = 32'h8000_0000;

endpackage

// File: rtl/lfsr8.sv
// rtl/lfsr8.sv - 8-bit Fibonacci LFSR (taps 8,6,5,4) used for pseudo-random response delay
module lfsr8 (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] seed,
    output logic [7:0] out
);

    logic fb;

    assign fb = out[7] ^ out[5] ^ out[4] ^ out[3];

    // Free-running shift every cycle; seed must be non-zero or the sequence locks up.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out <= seed;
        end else begin
            out <= {out[6:0], fb};
        end
    end

endmodule

// File: rtl/axi_rd_sram_slave.sv
// rtl/axi_rd_sram_slave.sv - AXI4-Lite read responder over word SRAM; AXI_RD_RAND_DELAY_EN selects LFSR delay
module axi_rd_sram_slave
    import axi_rd_pkg::*;
#(
    parameter int                ADDR_W     = 32,
    parameter int                DATA_W     = 32,
    parameter int                DEPTH      = 1024,
    parameter logic [ADDR_W-1:0] BASE       = ADDR_W'(DEFAULT_BASE),
    parameter int                LATENCY    = 2,
    parameter logic [7:0]        DELAY_MASK = 8'h1F,
    parameter logic [7:0]        LFSR_SEED  = 8'hA5
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [ADDR_W-1:0]        araddr,
    input  logic                     arvalid,
    output logic                     arready,
    output logic [DATA_W-1:0]        rdata,
    output logic [1:0]               rresp,
    output logic                     rvalid,
    input  logic                     rready,
    input  logic                     ld_we,
    input  logic [$clog2(DEPTH)-1:0] ld_idx,
    input  logic [DATA_W-1:0]        ld_wdata
);

    localparam int                IDX_W = $clog2(DEPTH);
    localparam logic [ADDR_W-1:0] SPAN  = ADDR_W'(DEPTH * 4);

    state_t            state;
    state_t            state_nxt;
    logic [7:0]        cnt;
    logic [7:0]        delay;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] off;
    logic [IDX_W-1:0]  idx;
    logic              hit;
    logic              ar_hs;
    logic              r_hs;
    logic              rd_fire;

    logic [DATA_W-1:0] mem [DEPTH];

`ifdef AXI_RD_RAND_DELAY_EN
    logic [7:0] lfsr_out;

    lfsr8 u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .seed (LFSR_SEED),
        .out  (lfsr_out)
    );

    assign delay = lfsr_out & DELAY_MASK;
`else
    assign delay = 8'(LATENCY);
`endif

    assign ar_hs   = arvalid && arready;
    assign r_hs    = rvalid && rready;
    assign rd_fire = (state == WAIT) && (cnt == 8'd0);

    // Addresses below BASE wrap to large offsets, so one unsigned compare covers both bounds.
    assign off = addr_q - BASE;
    assign hit = (off < SPAN) && (addr_q[1:0] == 2'b00);
    assign idx = off[IDX_W+1:2];

    // Program-image load port: no reset, writes in any state.
    always_ff @(posedge clk) begin
        if (ld_we) begin
            mem[ld_idx] <= ld_wdata;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: one outstanding read, AR ignored outside IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (ar_hs) state_nxt = WAIT;
            WAIT:    if (cnt == 8'd0) state_nxt = RESP;
            RESP:    if (r_hs) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Registered handshake outputs, delay counter and response capture.
    // arready/rvalid follow the next state so neither depends combinationally on the inputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            arready <= 1'b0;
            rvalid  <= 1'b0;
            rdata   <= '0;
            rresp   <= RESP_OKAY;
            cnt     <= 8'd0;
            addr_q  <= '0;
        end else begin
            arready <= (state_nxt == IDLE);
            rvalid  <= (state_nxt == RESP);
            if (ar_hs) begin
                addr_q <= araddr;
                cnt    <= delay;
            end else if ((state == WAIT) && (cnt != 8'd0)) begin
                cnt <= cnt - 8'd1;
            end
            // Same-edge load to this index is not visible here: old data is returned.
            if (rd_fire) begin
                rdata <= hit ? mem[idx] : '0;
                rresp <= hit ? RESP_OKAY : RESP_SLVERR;
            end
        end
    end

endmodule

// File: tb/tb_axi_rd_sram_slave.sv
// tb/tb_axi_rd_sram_slave.sv - self-checking bench for axi_rd_sram_slave (honours AXI_RD_RAND_DELAY_EN)
module tb_axi_rd_sram_slave;

    localparam int          DEPTH   = 1024;
    localparam int          LATENCY = 2;
    localparam logic [31:0] BASE    = 32'h8000_0000;
    localparam longint      BASE_L  = 64'h8000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] araddr = '0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready = 1'b0;
    logic        ld_we = 1'b0;
    logic [9:0]  ld_idx = '0;
    logic [31:0] ld_wdata = '0;

    int checks = 0;
    int passed = 0;

    logic [31:0] mdl [DEPTH];
    bit          seen [32];

    typedef struct {
        logic [31:0] addr;
        int          hold;
        logic [31:0] exp_data;
        logic [1:0]  exp_resp;
    } vec_t;

    vec_t vecs [7];

    always #5 clk = ~clk;

    axi_rd_sram_slave #(
        .ADDR_W     (32),
        .DATA_W     (32),
        .DEPTH      (DEPTH),
        .BASE       (BASE),
        .LATENCY    (LATENCY),
        .DELAY_MASK (8'h1F),
        .LFSR_SEED  (8'hA5)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .araddr   (araddr),
        .arvalid  (arvalid),
        .arready  (arready),
        .rdata    (rdata),
        .rresp    (rresp),
        .rvalid   (rvalid),
        .rready   (rready),
        .ld_we    (ld_we),
        .ld_idx   (ld_idx),
        .ld_wdata (ld_wdata)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference decode: a word inside [BASE, BASE+DEPTH*4) and 4-byte aligned hits.
    task automatic exp_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] r);
        longint ua;
        ua = longint'(a);
        if (ua >= BASE_L && ua < BASE_L + DEPTH * 4 && (ua % 4) == 0) begin
            d = mdl[int'((ua - BASE_L) / 4)];
            r = 2'b00;
        end else begin
            d = 32'h0;
            r = 2'b10;
        end
    endtask

    task automatic lat_chk(input string tag, input int lat);
`ifdef AXI_RD_RAND_DELAY_EN
        chk({tag, "_lat_range"}, (lat >= 0 && lat <= 31), 1);
        if (lat >= 0 && lat <= 31) seen[lat] = 1'b1;
`else
        chk({tag, "_latency"}, lat, LATENCY);
`endif
    endtask

    task automatic load_word(input int i, input logic [31:0] v);
        @(negedge clk);
        ld_we = 1'b1; ld_idx = 10'(i); ld_wdata = v;
        @(negedge clk);
        ld_we = 1'b0;
        mdl[i] = v;
    endtask

    // One full read; returns captured response and delay (edges after T+1 until rvalid).
    task automatic do_read(input logic [31:0] a, input int hold, input string tag,
                           output logic [31:0] d, output logic [1:0] r, output int lat);
        int k;
        bit bad_ar;
        bit bad_hold;
        d = '0; r = '0; lat = -1;
        @(negedge clk);
        araddr = a; arvalid = 1'b1;
        k = 0;
        while (!arready && k < 50) begin @(negedge clk); k++; end
        if (!arready) begin
            chk({tag, "_ar_timeout"}, 0, 1);
            arvalid = 1'b0;
            return;
        end
        @(negedge clk);
        arvalid = 1'b0;
        k = 0; bad_ar = 0;
        while (!rvalid && k < 300) begin
            if (arready) bad_ar = 1;
            @(negedge clk);
            k++;
        end
        if (!rvalid) begin
            chk({tag, "_rvalid_timeout"}, 0, 1);
            return;
        end
        if (arready) bad_ar = 1;
        lat = k - 1;
        d = rdata; r = rresp;
        bad_hold = 0;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (!rvalid || rdata !== d || rresp !== r || arready) bad_hold = 1;
        end
        rready = 1'b1;
        @(negedge clk);
        rready = 1'b0;
        chk({tag, "_arready_low_in_flight"}, bad_ar, 0);
        if (hold > 0) chk({tag, "_hold_stable"}, bad_hold, 0);
        chk({tag, "_after_handshake"}, {rvalid, arready}, 2'b01);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", passed, checks);
        $fatal(1);
    end

    initial begin
        logic [31:0] d, ed, a;
        logic [1:0]  r, er;
        int          lat, sel, distinct;

        vecs[0] = '{32'h8000_0000, 0, 32'h0000_0413, 2'b00};
        vecs[1] = '{32'h8000_0002, 0, 32'h0000_0000, 2'b10};
        vecs[2] = '{32'h8000_1000, 0, 32'h0000_0000, 2'b10};
        vecs[3] = '{32'h8000_0004, 5, 32'h1234_5678, 2'b00};
        vecs[4] = '{32'h8000_0FFC, 2, 32'hDEAD_BEEF, 2'b00};
        vecs[5] = '{32'h7FFF_FFFC, 0, 32'h0000_0000, 2'b10};
        vecs[6] = '{32'h8000_0FFE, 1, 32'h0000_0000, 2'b10};

        repeat (3) @(negedge clk);
        chk("reset_arready", arready, 0);
        chk("reset_rvalid", rvalid, 0);
        chk("reset_rdata", rdata, 0);
        chk("reset_rresp", rresp, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("first_edge_arready", arready, 1);
        chk("first_edge_rvalid", rvalid, 0);

        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            ld_we = 1'b1; ld_idx = 10'(i);
            case (i)
                0:       ld_wdata = 32'h0000_0413;
                1:       ld_wdata = 32'h1234_5678;
                1023:    ld_wdata = 32'hDEAD_BEEF;
                default: ld_wdata = $urandom;
            endcase
            mdl[i] = ld_wdata;
        end
        @(negedge clk);
        ld_we = 1'b0;
        chk("idle_no_traffic_rvalid", rvalid, 0);

        for (int i = 0; i < 7; i++) begin
            do_read(vecs[i].addr, vecs[i].hold, $sformatf("vec%0d", i), d, r, lat);
            chk($sformatf("vec%0d_rdata", i), d, vecs[i].exp_data);
            chk($sformatf("vec%0d_rresp", i), r, vecs[i].exp_resp);
            if (lat >= 0) lat_chk($sformatf("vec%0d", i), lat);
        end

`ifndef AXI_RD_RAND_DELAY_EN
        // Load to the same word on the edge that performs the SRAM read: old data comes back.
        @(negedge clk);
        araddr = BASE + 32'd8; arvalid = 1'b1;
        @(negedge clk);
        arvalid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        ld_we = 1'b1; ld_idx = 10'd2; ld_wdata = 32'hCAFE_F00D;
        @(negedge clk);
        ld_we = 1'b0;
        chk("rbw_rvalid", rvalid, 1);
        chk("rbw_old_data", rdata, mdl[2]);
        rready = 1'b1;
        @(negedge clk);
        rready = 1'b0;
        mdl[2] = 32'hCAFE_F00D;
        do_read(BASE + 32'd8, 0, "rbw_reread", d, r, lat);
        chk("rbw_new_data", d, 32'hCAFE_F00D);
`endif

        // Asynchronous reset while a read is in flight.
        @(negedge clk);
        araddr = BASE + 32'd4; arvalid = 1'b1;
        @(negedge clk);
        arvalid = 1'b0;
        #1 rst = 1'b0;
        #1;
        chk("async_rst_rvalid", rvalid, 0);
        chk("async_rst_arready", arready, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("post_rst_arready", arready, 1);
        chk("post_rst_rvalid", rvalid, 0);
        do_read(BASE + 32'd4, 0, "post_rst_read", d, r, lat);
        chk("post_rst_rdata", d, 32'h1234_5678);
        chk("post_rst_rresp", r, 2'b00);

        for (int n = 0; n < 200; n++) begin
            if ($urandom_range(0, 3) == 0) load_word(int'($urandom_range(0, DEPTH - 1)), $urandom);
            sel = int'($urandom_range(0, 9));
            a = BASE + 32'($urandom_range(0, DEPTH - 1)) * 4;
            if (sel == 7) a = a + 32'($urandom_range(1, 3));
            else if (sel == 8) a = BASE + 32'(DEPTH * 4) + 32'($urandom_range(0, 1000));
            else if (sel == 9) a = $urandom;
            exp_read(a, ed, er);
            do_read(a, int'($urandom_range(0, 3)), $sformatf("rnd%0d", n), d, r, lat);
            chk($sformatf("rnd%0d_rdata_a%0h", n, a), d, ed);
            chk($sformatf("rnd%0d_rresp_a%0h", n, a), r, er);
            if (lat >= 0) lat_chk($sformatf("rnd%0d", n), lat);
        end

`ifdef AXI_RD_RAND_DELAY_EN
        distinct = 0;
        for (int i = 0; i < 32; i++) if (seen[i]) distinct++;
        chk("distinct_latencies", distinct >= 2, 1);
`else
        distinct = 0;
`endif

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
